// File: rtl/tx_pause_gen.sv
// tx_pause_gen: builds 60-byte 802.3x PAUSE frames (no FCS) and streams 8 x 64-bit beats; first beat 1 cycle after the registered grant.
// Beats hold while tx_ready=0; requests arriving while busy queue as one pending frame. Define PAUSE_REFRESH_EN for auto-resend while pause_hold=1.
module tx_pause_gen #(
    parameter logic [47:0] PAUSE_DA       = 48'h0180C2000001,
    parameter logic [15:0] PAUSE_TYPE     = 16'h8808,
    parameter logic [15:0] PAUSE_OPCODE   = 16'h0001,
    parameter logic [15:0] REFRESH_CYCLES = 16'd4096
) (
    input  logic        txclk,
    input  logic        reset,
    input  logic [47:0] MAC_Addr,
    input  logic        pause_send,
    input  logic [15:0] pause_quanta,
    input  logic        pause_hold,
    input  logic        tx_grant,
    input  logic        tx_ready,
    output logic        tx_req,
    output logic        tx_valid,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_ben,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        pause_busy,
    output logic        pause_done
);

    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic        grant_q, grant_d;
    logic        pending_q, pending_d;
    logic [15:0] pend_quanta_q, pend_quanta_d;
    logic [15:0] quanta_q, quanta_d;
    logic [47:0] sa_q, sa_d;

    logic        tx_req_q, tx_req_d;
    logic        tx_valid_q, tx_valid_d;
    logic [63:0] tx_data_q, tx_data_d;
    logic [7:0]  tx_ben_q, tx_ben_d;
    logic        tx_sof_q, tx_sof_d;
    logic        tx_eof_q, tx_eof_d;
    logic        pause_busy_q, pause_busy_d;
    logic        pause_done_q, pause_done_d;

    logic        req_in;
    logic [15:0] req_quanta;
    logic        beat_acc;

    assign beat_acc = tx_valid_q & tx_ready;

`ifdef PAUSE_REFRESH_EN
    logic [15:0] refresh_q, refresh_d;
    logic        refresh_req;

    // Fires once as the countdown reaches zero; it then idles at 0 until the next pause_done reloads it.
    assign refresh_req = pause_hold & ~pause_done_q & (refresh_q == 16'd1);

    always_comb begin
        refresh_d = refresh_q;
        if (!pause_hold) begin
            refresh_d = 16'd0;
        end else if (pause_done_q) begin
            refresh_d = REFRESH_CYCLES;
        end else if (refresh_q != 16'd0) begin
            refresh_d = refresh_q - 16'd1;
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            refresh_q <= 16'd0;
        end else begin
            refresh_q <= refresh_d;
        end
    end

    assign req_in     = pause_send | refresh_req;
    assign req_quanta = pause_send ? pause_quanta : quanta_q;
`else
    logic unused_refresh;

    assign unused_refresh = ^{pause_hold, REFRESH_CYCLES};
    assign req_in         = pause_send;
    assign req_quanta     = pause_quanta;
`endif

    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_in) state_d = REQ;
            REQ:     if (grant_q) state_d = SEND;
            SEND:    if (beat_acc && (beat_q == 3'd7)) state_d = DONE;
            DONE:    state_d = (pending_q || req_in) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        quanta_d      = quanta_q;
        sa_d          = sa_q;
        pending_d     = pending_q;
        pend_quanta_d = pend_quanta_q;
        beat_d        = 3'd0;
        grant_d       = (state_q == REQ) & tx_grant & ~grant_q;

        if (state_q == SEND) begin
            beat_d = beat_acc ? beat_q + 3'd1 : beat_q;
        end

        // A request seen in DONE is newer than the pending one, so it wins the quanta.
        if (state_q == IDLE) begin
            if (req_in) begin
                quanta_d = req_quanta;
                sa_d     = MAC_Addr;
            end
        end else if (state_q == DONE) begin
            if (req_in || pending_q) begin
                quanta_d  = req_in ? req_quanta : pend_quanta_q;
                sa_d      = MAC_Addr;
                pending_d = 1'b0;
            end
        end else if (req_in) begin
            pending_d     = 1'b1;
            pend_quanta_d = req_quanta;
        end
    end

    always_comb begin
        tx_req_d     = (state_d == REQ);
        tx_valid_d   = (state_d == SEND);
        pause_busy_d = (state_d != IDLE);
        pause_done_d = (state_d == DONE);
        tx_data_d    = 64'h0;
        tx_ben_d     = 8'h00;
        tx_sof_d     = 1'b0;
        tx_eof_d     = 1'b0;

        // Byte n of the beat sits in [8n+7:8n], so wire order reads right to left here.
        if (state_d == SEND) begin
            tx_ben_d = 8'hFF;
            case (beat_d)
                3'd0: begin
                    tx_data_d = {sa_q[39:32], sa_q[47:40],
                                 PAUSE_DA[7:0], PAUSE_DA[15:8], PAUSE_DA[23:16],
                                 PAUSE_DA[31:24], PAUSE_DA[39:32], PAUSE_DA[47:40]};
                    tx_sof_d  = 1'b1;
                end
                3'd1: begin
                    tx_data_d = {PAUSE_OPCODE[7:0], PAUSE_OPCODE[15:8],
                                 PAUSE_TYPE[7:0], PAUSE_TYPE[15:8],
                                 sa_q[7:0], sa_q[15:8], sa_q[23:16], sa_q[31:24]};
                end
                3'd2: begin
                    tx_data_d = {48'h0, quanta_q[7:0], quanta_q[15:8]};
                end
                3'd7: begin
                    tx_ben_d = 8'h0F;
                    tx_eof_d = 1'b1;
                end
                default: begin
                    tx_data_d = 64'h0;
                end
            endcase
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            beat_q        <= 3'd0;
            grant_q       <= 1'b0;
            pending_q     <= 1'b0;
            pend_quanta_q <= 16'h0;
            quanta_q      <= 16'h0;
            sa_q          <= 48'h0;
            tx_req_q      <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 64'h0;
            tx_ben_q      <= 8'h00;
            tx_sof_q      <= 1'b0;
            tx_eof_q      <= 1'b0;
            pause_busy_q  <= 1'b0;
            pause_done_q  <= 1'b0;
        end else begin
            beat_q        <= beat_d;
            grant_q       <= grant_d;
            pending_q     <= pending_d;
            pend_quanta_q <= pend_quanta_d;
            quanta_q      <= quanta_d;
            sa_q          <= sa_d;
            tx_req_q      <= tx_req_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            tx_ben_q      <= tx_ben_d;
            tx_sof_q      <= tx_sof_d;
            tx_eof_q      <= tx_eof_d;
            pause_busy_q  <= pause_busy_d;
            pause_done_q  <= pause_done_d;
        end
    end

    assign tx_req     = tx_req_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign tx_ben     = tx_ben_q;
    assign tx_sof     = tx_sof_q;
    assign tx_eof     = tx_eof_q;
    assign pause_busy = pause_busy_q;
    assign pause_done = pause_done_q;

endmodule
